// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM controller and its refresh timer.
package dram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        COL,
        ACK,
        PRE,
        REF_CAS,
        REF_RAS,
        REF_HOLD
    } dram_state_t;

    localparam int ROW_BITS             = 10;
    localparam int COL_BITS             = 11;
    localparam int DEF_REFRESH_INTERVAL = 240;
    localparam int DEF_RAS_PRECHARGE    = 2;
    // Width of the shared precharge / refresh-hold wait counter.
    localparam int WAIT_CNT_W           = 4;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter; raises pending on expiry until the FSM acknowledges it.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
    input  logic CLK,
    input  logic RST,
    input  logic ack,
    output logic pending
);

    localparam int                CNT_W  = $clog2(REFRESH_INTERVAL);
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(REFRESH_INTERVAL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             w_expire;

    assign w_expire = (r_cnt == '0);

    // A fresh expiry outranks a same-cycle ack; an expiry while already pending is absorbed.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt     <= RELOAD;
            r_pending <= 1'b0;
        end else begin
            r_cnt     <= w_expire ? RELOAD : r_cnt - 1'b1;
            r_pending <= w_expire | (r_pending & ~ack);
        end
    end

    assign pending = r_pending;

endmodule

// File: rtl/dram_controller.sv
// RAS/CAS sequencer for the 68010 DRAM bank with CAS-before-RAS refresh; all outputs registered.
module dram_controller
    import dram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int RAS_PRECHARGE    = DEF_RAS_PRECHARGE
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RAM_LOWER,
    input  logic                RAM_UPPER,
    input  logic                AS,
    input  logic                RW,
    input  logic [21:1]         ADDR,
    output logic [COL_BITS-1:0] MA,
    output logic                RAS,
    output logic                CASL,
    output logic                CASU,
    output logic                WE,
    output logic                DTACK_DRAM
);

    dram_state_t           r_state, w_state_next, w_pick;
    logic [2:0]            r_sync1, r_sync2;
    logic [WAIT_CNT_W-1:0] r_wait, w_wait_next;
    logic [COL_BITS-1:0]   r_ma, w_ma_next;
    logic                  r_ras, r_casl, r_casu, r_we, r_dtack;
    logic                  w_ras_next, w_casl_next, w_casu_next, w_we_next, w_dtack_next;
    logic                  w_as_high, w_req, w_pending, w_ref_ack;

    // Synchronizer bits: [2] AS, [1] RAM_LOWER, [0] RAM_UPPER.
    assign w_as_high = r_sync2[2];
    assign w_req     = ~r_sync2[2] & ~(r_sync2[1] & r_sync2[0]);
    assign w_pick    = w_pending ? REF_CAS : (w_req ? ROW : IDLE);
    assign w_ref_ack = (w_state_next == REF_CAS);

    dram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .CLK    (CLK),
        .RST    (RST),
        .ack    (w_ref_ack),
        .pending(w_pending)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_wait  <= WAIT_CNT_W'(RAS_PRECHARGE);
            r_ma    <= '0;
            r_ras   <= 1'b1;
            r_casl  <= 1'b1;
            r_casu  <= 1'b1;
            r_we    <= 1'b1;
            r_dtack <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_sync1 <= {AS, RAM_LOWER, RAM_UPPER};
            r_sync2 <= r_sync1;
            r_wait  <= w_wait_next;
            r_ma    <= w_ma_next;
            r_ras   <= w_ras_next;
            r_casl  <= w_casl_next;
            r_casu  <= w_casu_next;
            r_we    <= w_we_next;
            r_dtack <= w_dtack_next;
        end
    end

    // Out of reset IDLE also waits out a full precharge, hence the shared wait counter there.
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        case (r_state)
            IDLE, PRE: begin
                if (r_wait != '0) w_wait_next  = r_wait - 1'b1;
                else              w_state_next = w_pick;
            end
            ROW:      w_state_next = w_as_high ? PRE : COL;
            COL:      w_state_next = w_as_high ? PRE : ACK;
            ACK:      if (w_as_high) w_state_next = PRE;
            REF_CAS:  w_state_next = REF_RAS;
            REF_RAS:  w_state_next = REF_HOLD;
            REF_HOLD: begin
                if (r_wait != '0) w_wait_next  = r_wait - 1'b1;
                else              w_state_next = PRE;
            end
            default:  w_state_next = IDLE;
        endcase
        if (w_state_next == PRE && r_state != PRE)
            w_wait_next = WAIT_CNT_W'(RAS_PRECHARGE - 1);
        if (w_state_next == REF_HOLD && r_state != REF_HOLD)
            w_wait_next = WAIT_CNT_W'(1);
    end

    // Strobes are decoded from the next state so each lands on the same edge as its state.
    always_comb begin
        w_ma_next    = r_ma;
        w_ras_next   = r_ras;
        w_casl_next  = r_casl;
        w_casu_next  = r_casu;
        w_we_next    = r_we;
        w_dtack_next = r_dtack;
        case (w_state_next)
            ROW: begin
                w_ma_next    = {1'b0, ADDR[21:12]};
                w_ras_next   = 1'b0;
                w_casl_next  = 1'b1;
                w_casu_next  = 1'b1;
                w_we_next    = 1'b1;
                w_dtack_next = 1'b1;
            end
            COL: begin
                w_ma_next    = ADDR[11:1];
                w_ras_next   = 1'b0;
                w_casl_next  = r_sync2[1];
                w_casu_next  = r_sync2[0];
                w_we_next    = RW;
                w_dtack_next = 1'b1;
            end
            ACK: w_dtack_next = 1'b0;
            REF_CAS, REF_RAS, REF_HOLD: begin
                w_ras_next   = (w_state_next == REF_CAS);
                w_casl_next  = 1'b0;
                w_casu_next  = 1'b0;
                w_we_next    = 1'b1;
                w_dtack_next = 1'b1;
            end
            default: begin
                w_ras_next   = 1'b1;
                w_casl_next  = 1'b1;
                w_casu_next  = 1'b1;
                w_we_next    = 1'b1;
                w_dtack_next = 1'b1;
            end
        endcase
    end

    assign MA         = r_ma;
    assign RAS        = r_ras;
    assign CASL       = r_casl;
    assign CASU       = r_casu;
    assign WE         = r_we;
    assign DTACK_DRAM = r_dtack;

endmodule

// File: tb/tb_dram_controller.sv
// Directed and randomized checks of dram_controller against a timeline model of access and refresh scheduling.
module tb_dram_controller;

    localparam int REFI     = 16;
    localparam int PRE_CYC  = 2;
    localparam int REF_BUSY = 4 + PRE_CYC;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        RAM_LOWER = 1'b1;
    logic        RAM_UPPER = 1'b1;
    logic        AS = 1'b1;
    logic        RW = 1'b1;
    logic [21:1] ADDR = '0;
    logic [10:0] MA;
    logic        RAS, CASL, CASU, WE, DTACK_DRAM;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready;
    int next_ref;

    dram_controller #(
        .REFRESH_INTERVAL(REFI),
        .RAS_PRECHARGE   (PRE_CYC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RAM_LOWER (RAM_LOWER),
        .RAM_UPPER (RAM_UPPER),
        .AS        (AS),
        .RW        (RW),
        .ADDR      (ADDR),
        .MA        (MA),
        .RAS       (RAS),
        .CASL      (CASL),
        .CASU      (CASU),
        .WE        (WE),
        .DTACK_DRAM(DTACK_DRAM)
    );

    always #5 CLK = ~CLK;

    // Edge count since reset release: value N at a negedge means N rising edges have passed.
    always @(posedge CLK) begin
        if (!RST) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Controller is free to decide at edge 2 after reset; first refresh request at edge REFI.
    task automatic model_reset();
        ready    = 2;
        next_ref = REFI;
    endtask

    // Edge at which the access visible from edge v is granted, serving any earlier refreshes first.
    task automatic model_decide(input int v, output int x);
        int s;
        x = (v > ready) ? v : ready;
        while (next_ref <= x) begin
            s        = (next_ref > ready) ? next_ref : ready;
            ready    = s + REF_BUSY;
            next_ref = (s / REFI + 1) * REFI;
            x        = (v > ready) ? v : ready;
        end
    endtask

    task automatic do_access(input logic [21:0] baddr, input logic rw, input logic low,
                             input logic up, input int hold, input bit rst_at_ack, output int lat);
        int a0, x, b0, rel;
        logic [10:0] erow, ecol;
        erow = 11'(baddr >> 12);
        ecol = 11'((baddr >> 1) & 22'h7FF);
        a0 = cyc;
        AS = 1'b0; ADDR = baddr[21:1]; RW = rw; RAM_LOWER = low; RAM_UPPER = up;
        model_decide(a0 + 2, x);
        lat = -1;
        while (cyc < x + 3) begin
            tick();
            if (lat < 0 && DTACK_DRAM === 1'b0) lat = cyc - a0;
            if (cyc == x) chk("idle_ras", RAS, 1);
            if (cyc == x + 1) begin
                chk("row_ras", RAS, 0);
                chk("row_ma", MA, erow);
                chk("row_cas", {CASL, CASU}, 2'b11);
            end
            if (cyc == x + 2) begin
                chk("col_ma", MA, ecol);
                chk("col_cas", {CASL, CASU}, {low, up});
                chk("col_we", WE, rw);
                chk("col_dtack", DTACK_DRAM, 1);
            end
        end
        chk("ack_lat", lat, x + 3 - a0);
        chk("ack_strobes", {RAS, CASL, CASU, WE}, {1'b0, low, up, rw});
        if (rst_at_ack) begin
            RST = 1'b0; AS = 1'b1; RAM_LOWER = 1'b1; RAM_UPPER = 1'b1;
            #1;
            chk("rst_strobes", {RAS, CASL, CASU, WE, DTACK_DRAM}, 5'h1F);
            chk("rst_ma", MA, 0);
            tick();
            tick();
            RST = 1'b1;
            model_reset();
        end else begin
            repeat (hold) tick();
            b0 = cyc;
            AS = 1'b1; RAM_LOWER = 1'b1; RAM_UPPER = 1'b1;
            rel = -1;
            while (cyc < b0 + 3) begin
                tick();
                if (rel < 0 && DTACK_DRAM === 1'b1) rel = cyc - b0;
            end
            chk("rel_lat", rel, 3);
            chk("pre_strobes", {RAS, CASL, CASU, WE}, 4'hF);
            ready = b0 + 4;
        end
        $display("access addr=%06h rw=%0b sel=%0b%0b grant_edge=%0d dtack_lat=%0d", baddr, rw, up, low, x, lat);
    endtask

    initial begin
        int lat, m, a0, x, sel, gap;
        logic [21:0] baddr;
        logic        exp_ras, exp_cas;

        repeat (3) tick();
        chk("reset_strobes", {RAS, CASL, CASU, WE, DTACK_DRAM}, 5'h1F);
        chk("reset_ma", MA, 0);
        RST = 1'b1;
        model_reset();

        // Idle: refresh every REFI edges, CAS one edge ahead of a 3-edge RAS pulse.
        for (int e = 1; e <= 40; e++) begin
            tick();
            exp_ras = !(e >= REFI && (e % REFI) >= 2 && (e % REFI) <= 4);
            exp_cas = !(e >= REFI && (e % REFI) >= 1 && (e % REFI) <= 4);
            chk("ref_ras", RAS, exp_ras);
            chk("ref_cas", {CASL, CASU}, {exp_cas, exp_cas});
            chk("ref_dtack", DTACK_DRAM, 1);
            chk("ref_we", WE, 1);
        end
        $display("refresh idle window checked through cyc=%0d", cyc);

        // Byte address 0x012345: row bits 21..12 = 0x012, column bits 11..1 = 0x1A2.
        do_access(22'h012345, 1'b1, 1'b0, 1'b0, 0, 1'b0, lat);
        chk("word_lat", lat, 5);

        do_access(22'h2ABCDE, 1'b0, 1'b1, 1'b0, 1, 1'b0, lat);
        chk("bytew_lat_ge5", (lat >= 5), 1);

        m = (cyc + 8) / REFI + 2;
        while (cyc < m * REFI - 2) tick();
        do_access(22'h155554, 1'b1, 1'b0, 1'b0, 0, 1'b0, lat);
        chk("ref_first_lat", lat, 5 + 4 + PRE_CYC);

        do_access(22'h0F0F0E, 1'b1, 1'b0, 1'b1, 0, 1'b1, lat);

        // Abort: AS rises while the access is still in ROW.
        while (cyc < 3) tick();
        a0 = cyc;
        AS = 1'b0; RAM_LOWER = 1'b0; RAM_UPPER = 1'b0; RW = 1'b1;
        model_decide(a0 + 2, x);
        tick();
        AS = 1'b1; RAM_LOWER = 1'b1; RAM_UPPER = 1'b1;
        while (cyc < x + 4) begin
            tick();
            chk("abort_dtack", DTACK_DRAM, 1);
            if (cyc == x + 1) chk("abort_row_ras", RAS, 0);
            if (cyc == x + 2) chk("abort_pre", {RAS, CASL, CASU}, 3'b111);
        end
        ready = x + 3;
        $display("abort in ROW checked grant_edge=%0d", x);

        do_access(22'h3FFFFE, 1'b1, 1'b0, 1'b0, 0, 1'b0, lat);
        chk("post_reset_lat", lat, 5);

        for (int i = 0; i < 25; i++) begin
            gap = $urandom_range(1, 12);
            repeat (gap) tick();
            baddr = 22'($urandom) & 22'h3FFFFE;
            sel   = $urandom_range(0, 2);
            do_access(baddr, 1'($urandom_range(0, 1)), (sel == 1), (sel == 0),
                      $urandom_range(0, 3), 1'b0, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
